mcpu_core_stage_dmem: RTL and testbench
=======================================

MCPU_CORE_STAGE_DMEM -- requirements
Module: MCPU_CORE_stage_dmem

Interface
REQ-001 SHALL have ports: clkrst_core_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: clkrst_core_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: dtlb2pc_paddr  in  32  physical address from DTLB stage; dtlb2pc_pf  in  1  page fault from DTLB.
REQ-004 SHALL have ports: pc_oper_type  in  2  operation class (LSU = memory op); pc_is_store  in  1; pc_size  in  2  00 byte, 01 half, 10 word; pc_signed  in  1  sign-extend loads; pc_wdata  in  32  store data (low bits significant).
REQ-005 SHALL have ports: pc_valid_in  in  1; pc_ready_in  out  1  stage accepts this cycle; pc_valid_out  out  1; pc_out_ok  in  1  downstream accepts; pipe_flush  in  1.
REQ-006 SHALL have ports: mem_req  out  1; mem_addr  out  [31:2]; mem_we  out  1; mem_be  out  4; mem_wdata  out  32; mem_gnt  in  1; mem_rvalid  in  1  response/ack; mem_rdata  in  32.
REQ-007 SHALL have ports: pc2wb_data  out  32  formatted load data; pc2wb_pf  out  1  page fault; pc2wb_misalign  out  1  misaligned access.

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT, DONE, DRAIN.
REQ-009 Transfer in: pc_valid_in & pc_ready_in; pc_ready_in = (IDLE) | (DONE & pc_out_ok); 0 in REQ, WAIT, DRAIN.
REQ-010 On transfer, SHALL latch paddr, type, store flag, size, signed, wdata.
REQ-011 Misaligned = LSU & ((half & paddr[0]) | (word & paddr[1:0]!=0)); size 11 treated as word.
REQ-012 Non-LSU, pf=1 or misaligned transfer: go DONE next cycle, no mem_req, pc2wb_pf/pc2wb_misalign set accordingly, pc2wb_data=0.
REQ-013 Otherwise go REQ; mem_req=1 only in REQ; mem_addr/mem_we/mem_be/mem_wdata stable from latched values while in REQ.
REQ-014 mem_be: byte = 4'b0001<<paddr[1:0]; half = 4'b0011<<paddr[1:0]; word = 4'b1111.
REQ-015 mem_wdata: byte replicated to all 4 lanes, half replicated to both halves, word as-is.
REQ-016 REQ & mem_gnt -> WAIT; same-cycle mem_gnt & mem_rvalid -> DONE directly. Stores also wait for mem_rvalid as ack.
REQ-017 WAIT & mem_rvalid -> DONE; load data captured into pc2wb_data that edge.
REQ-018 Load formatting: select lane by paddr[1:0] (byte) or paddr[1] (half); zero- or sign-extend per pc_signed; word unmodified; stores output pc2wb_data=0.
REQ-019 pc_valid_out = (state==DONE); pc2wb_* held stable until pc_out_ok.
REQ-020 DONE & pc_out_ok & no new transfer -> IDLE; with new transfer, process it as from IDLE (back-to-back, no bubble).
REQ-021 mem_rvalid outside WAIT/DRAIN (and outside REQ with gnt) SHALL be ignored.
REQ-022 pipe_flush priority over all other transitions, and blocks any transfer that cycle (pc_ready_in forced 0):
- IDLE, DONE -> IDLE, result dropped;
- REQ without mem_gnt -> IDLE, request withdrawn next cycle;
- REQ with mem_gnt (no rvalid), or WAIT without rvalid -> DRAIN;
- WAIT or REQ with mem_rvalid same cycle -> IDLE, data discarded.
REQ-023 DRAIN: mem_req=0, await mem_rvalid, discard, -> IDLE; further pipe_flush in DRAIN has no effect.
REQ-024 Latency (zero-wait memory: gnt in first REQ cycle, rvalid next): transfer at cycle N, mem_req at N+1, pc_valid_out at N+3.

Reset
REQ-025 On clkrst_core_rst at a clock edge: state IDLE, mem_req=0, pc_valid_out=0, pc2wb_data=0, pc2wb_pf=0, pc2wb_misalign=0, latched fields 0, regardless of state (including outstanding request; memory response after reset ignored).
REQ-026 During reset, pc_ready_in=0.

Verification
REQ-027 Load byte signed, paddr 0x1003, rdata 0x80AABBCC, gnt immediate, rvalid +1 -> mem_be 1000, mem_addr 0x400, pc2wb_data 0xFFFFFF80.
REQ-028 Store half, paddr 0x2002, wdata 0x1234 -> mem_we=1, mem_be 1100, mem_wdata 0x12341234; valid_out after rvalid, data 0.
REQ-029 Word load paddr 0x3001 -> no mem_req, pc_valid_out next cycle with pc2wb_misalign=1; pf=1 input -> pc2wb_pf=1, no mem_req.
REQ-030 gnt delayed 3 cycles and pc_out_ok low 2 cycles in DONE -> mem_req/address stable throughout, outputs held, then back-to-back second load accepted same cycle as out_ok.
REQ-031 pipe_flush in WAIT, rvalid 2 cycles later -> DRAIN, rvalid discarded, no pc_valid_out, pc_ready_in 1 next cycle after rvalid.
REQ-032 Reset asserted in WAIT -> all outputs zero next edge; late rvalid produces no pc_valid_out.

Source files
------------

// File: rtl/mcpu_core_stage_dmem.sv
// Data-memory pipeline stage of the MCPU core.
// Accepts one load/store from the DTLB stage, drives a single request to the
// data memory, waits for the response and hands a formatted result (or a
// page-fault / misalignment report) to writeback. A flush arriving while a
// request is in flight parks the stage in DRAIN until memory has answered,
// so a stale response can never be mistaken for a later request's data.
module mcpu_core_stage_dmem #(
    parameter logic [1:0] P_OPER_LSU = 2'd1
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    input  logic [31:0] dtlb2pc_paddr,
    input  logic        dtlb2pc_pf,
    input  logic [1:0]  pc_oper_type,
    input  logic        pc_is_store,
    input  logic [1:0]  pc_size,
    input  logic        pc_signed,
    input  logic [31:0] pc_wdata,
    input  logic        pc_valid_in,
    output logic        pc_ready_in,
    output logic        pc_valid_out,
    input  logic        pc_out_ok,
    input  logic        pipe_flush,
    output logic        mem_req,
    output logic [31:2] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc2wb_data,
    output logic        pc2wb_pf,
    output logic        pc2wb_misalign
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_paddr;
    logic [1:0]  r_operType;
    logic        r_isStore;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic [31:0] r_wbData;
    logic        r_wbPf;
    logic        r_wbMisalign;

    logic        w_isLsu;
    logic        w_misalign;
    logic        w_noMemAccess;
    logic        w_transfer;
    logic [31:0] w_loadData;

    // Pick the addressed lane out of the read word and extend it; size 2'b11
    // is handled like a word.
    function automatic logic [31:0] formatLoad(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  off,
        input logic [31:0] data
    );
        logic [7:0]  lane8;
        logic [15:0] lane16;
        logic [31:0] result;
        case (off)
            2'd0:    lane8 = data[7:0];
            2'd1:    lane8 = data[15:8];
            2'd2:    lane8 = data[23:16];
            default: lane8 = data[31:24];
        endcase
        lane16 = off[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   result = {{24{sgn & lane8[7]}}, lane8};
            2'b01:   result = {{16{sgn & lane16[15]}}, lane16};
            default: result = data;
        endcase
        return result;
    endfunction

    // Classify the incoming operation: only aligned, fault-free memory ops
    // ever reach the memory port.
    assign w_isLsu       = (pc_oper_type == P_OPER_LSU);
    assign w_misalign    = w_isLsu &
                           (((pc_size == 2'b01) & dtlb2pc_paddr[0]) |
                            (pc_size[1] & (dtlb2pc_paddr[1:0] != 2'b00)));
    assign w_noMemAccess = ~w_isLsu | dtlb2pc_pf | w_misalign;

    // A new op is taken when idle, or when the finished result is being
    // consumed this very cycle; a flush or reset blocks the handshake.
    assign pc_ready_in = ~clkrst_core_rst & ~pipe_flush &
                         ((r_state == ST_IDLE) |
                          ((r_state == ST_DONE) & pc_out_ok));
    assign w_transfer  = pc_valid_in & pc_ready_in;

    // Memory port and result handshake are decoded straight from the state
    // and latched fields, so they cannot glitch while a request is pending.
    assign mem_req        = (r_state == ST_REQ);
    assign mem_addr       = r_paddr[31:2];
    assign mem_we         = r_isStore & (r_operType == P_OPER_LSU);
    assign pc_valid_out   = (r_state == ST_DONE);
    assign pc2wb_data     = r_wbData;
    assign pc2wb_pf       = r_wbPf;
    assign pc2wb_misalign = r_wbMisalign;
    assign w_loadData     = formatLoad(r_size, r_signed, r_paddr[1:0], mem_rdata);

    // Byte enables and lane-replicated store data so memory can simply write
    // whichever lanes are enabled.
    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = r_wdata;
        case (r_size)
            2'b00: begin
                mem_be    = 4'b0001 << r_paddr[1:0];
                mem_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                mem_be    = 4'b0011 << r_paddr[1:0];
                mem_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = r_wdata;
            end
        endcase
    end

    // Stage controller: flush first, then new transfers, then the normal
    // request/response progression.
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            r_state      <= ST_IDLE;
            r_paddr      <= '0;
            r_operType   <= '0;
            r_isStore    <= 1'b0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_wbData     <= '0;
            r_wbPf       <= 1'b0;
            r_wbMisalign <= 1'b0;
        end else if (pipe_flush) begin
            case (r_state)
                ST_REQ:   r_state <= (mem_gnt & ~mem_rvalid) ? ST_DRAIN : ST_IDLE;
                ST_WAIT:  r_state <= mem_rvalid ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: r_state <= mem_rvalid ? ST_IDLE : ST_DRAIN;
                default:  r_state <= ST_IDLE;
            endcase
        end else if (w_transfer) begin
            r_paddr    <= dtlb2pc_paddr;
            r_operType <= pc_oper_type;
            r_isStore  <= pc_is_store;
            r_size     <= pc_size;
            r_signed   <= pc_signed;
            r_wdata    <= pc_wdata;
            r_wbData   <= '0;
            if (w_noMemAccess) begin
                r_state      <= ST_DONE;
                r_wbPf       <= dtlb2pc_pf;
                r_wbMisalign <= w_misalign;
            end else begin
                r_state      <= ST_REQ;
                r_wbPf       <= 1'b0;
                r_wbMisalign <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_REQ: begin
                    if (mem_gnt & mem_rvalid) begin
                        r_state      <= ST_DONE;
                        r_wbData     <= r_isStore ? 32'h0 : w_loadData;
                        r_wbPf       <= 1'b0;
                        r_wbMisalign <= 1'b0;
                    end else if (mem_gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_state      <= ST_DONE;
                        r_wbData     <= r_isStore ? 32'h0 : w_loadData;
                        r_wbPf       <= 1'b0;
                        r_wbMisalign <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (pc_out_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_core_stage_dmem.sv
// Directed bench for the data-memory stage. A small behavioural model turns
// each issued operation into the memory request and writeback result it must
// produce; a monitor compares the DUT against that model on every cycle.
module tb_mcpu_core_stage_dmem;

    localparam logic [1:0] LSU  = 2'd1;
    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;

    typedef struct packed {
        logic [31:0] data;
        logic        pf;
        logic        mis;
    } result_t;

    logic        clkrst_core_clk;
    logic        clkrst_core_rst;
    logic [31:0] dtlb2pc_paddr;
    logic        dtlb2pc_pf;
    logic [1:0]  pc_oper_type;
    logic        pc_is_store;
    logic [1:0]  pc_size;
    logic        pc_signed;
    logic [31:0] pc_wdata;
    logic        pc_valid_in;
    logic        pc_ready_in;
    logic        pc_valid_out;
    logic        pc_out_ok;
    logic        pipe_flush;
    logic        mem_req;
    logic [31:2] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] pc2wb_data;
    logic        pc2wb_pf;
    logic        pc2wb_misalign;

    int          vectorCount = 0;
    int          missCount   = 0;
    bit          monitorOn   = 0;
    bit          expReqActive = 0;
    logic [29:0] expAddr;
    logic        expWe;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    result_t     expQ[$];
    result_t     monExp;
    int          waited;

    mcpu_core_stage_dmem dut (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .dtlb2pc_paddr   (dtlb2pc_paddr),
        .dtlb2pc_pf      (dtlb2pc_pf),
        .pc_oper_type    (pc_oper_type),
        .pc_is_store     (pc_is_store),
        .pc_size         (pc_size),
        .pc_signed       (pc_signed),
        .pc_wdata        (pc_wdata),
        .pc_valid_in     (pc_valid_in),
        .pc_ready_in     (pc_ready_in),
        .pc_valid_out    (pc_valid_out),
        .pc_out_ok       (pc_out_ok),
        .pipe_flush      (pipe_flush),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .pc2wb_data      (pc2wb_data),
        .pc2wb_pf        (pc2wb_pf),
        .pc2wb_misalign  (pc2wb_misalign)
    );

    // Free-running core clock.
    initial clkrst_core_clk = 1'b0;
    always #5 clkrst_core_clk = ~clkrst_core_clk;

    // Access size in bytes.
    function automatic int byteCount(input logic [1:0] size);
        if (size == BYTE) return 1;
        if (size == HALF) return 2;
        return 4;
    endfunction

    // An access is misaligned when its address is not a multiple of its size.
    function automatic bit modelMisalign(input logic [1:0] typ, input logic [1:0] size,
                                         input logic [31:0] addr);
        return (typ == LSU) && ((int'(addr[1:0]) % byteCount(size)) != 0);
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [31:0] addr);
        int n;
        int off;
        int mask;
        n    = byteCount(size);
        off  = (n == 4) ? 0 : int'(addr[1:0]);
        mask = ((1 << n) - 1) << off;
        return mask[3:0];
    endfunction

    // Low n bytes of the store data, copied into every n-byte slot of the word.
    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] wdata);
        int     n;
        longint one;
        longint low;
        longint rep;
        n   = byteCount(size);
        one = 1;
        low = longint'({32'b0, wdata}) & ((one << (8 * n)) - 1);
        rep = 0;
        for (int k = 0; k < 4 / n; k++) rep = rep + (low << (8 * n * k));
        return rep[31:0];
    endfunction

    // Shift the addressed bytes down, then reinterpret as signed if requested.
    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sgn,
                                              input logic [31:0] addr, input logic [31:0] rdata);
        int     n;
        longint one;
        longint v;
        n   = byteCount(size);
        one = 1;
        v   = (longint'({32'b0, rdata}) >> (8 * int'(addr[1:0]))) & ((one << (8 * n)) - 1);
        if (n < 4 && sgn && v >= (one << (8 * n - 1))) v = v - (one << (8 * n));
        return v[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clkrst_core_clk);
        #1;
    endtask

    // Present one operation, wait (bounded) until it is taken, record what the
    // model says it must produce. Returns one cycle after the transfer edge.
    task automatic applyStimulus(input logic [1:0] typ, input logic isStore,
                                 input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic pf, input logic [31:0] rdata,
                                 input bit pushResult, output int waitCycles);
        result_t r;
        bit      mis;
        dtlb2pc_paddr = addr;
        dtlb2pc_pf    = pf;
        pc_oper_type  = typ;
        pc_is_store   = isStore;
        pc_size       = size;
        pc_signed     = sgn;
        pc_wdata      = wdata;
        pc_valid_in   = 1'b1;
        waitCycles    = 0;
        @(negedge clkrst_core_clk);
        while (!pc_ready_in && waitCycles < 20) begin
            stepCycle();
            @(negedge clkrst_core_clk);
            waitCycles++;
        end
        checkOutput("pc_ready_in at transfer", 32'(pc_ready_in), 32'd1);
        mis = modelMisalign(typ, size, addr);
        if (typ == LSU && !pf && !mis) begin
            expAddr      = addr[31:2];
            expWe        = isStore;
            expBe        = modelBe(size, addr);
            expWdata     = modelWdata(size, wdata);
            expReqActive = 1'b1;
            r.data       = isStore ? 32'h0 : modelLoad(size, sgn, addr, rdata);
            r.pf         = 1'b0;
            r.mis        = 1'b0;
        end else begin
            r.data = 32'h0;
            r.pf   = pf;
            r.mis  = mis;
        end
        if (pushResult) expQ.push_back(r);
        stepCycle();
        pc_valid_in = 1'b0;
    endtask

    // Play memory: grant after gntDelay cycles, answer rvalidDelay cycles after
    // the grant (0 = same cycle). Returns at the negedge where the result is due.
    task automatic serveMem(input int gntDelay, input int rvalidDelay, input logic [31:0] rdata);
        for (int i = 0; i < gntDelay; i++) begin
            mem_gnt = 1'b0;
            @(negedge clkrst_core_clk);
            checkOutput("mem_req held before gnt", 32'(mem_req), 32'd1);
            stepCycle();
        end
        mem_gnt = 1'b1;
        if (rvalidDelay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
        end
        @(negedge clkrst_core_clk);
        checkOutput("mem_req at gnt", 32'(mem_req), 32'd1);
        stepCycle();
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        expReqActive = 1'b0;
        if (rvalidDelay > 0) begin
            for (int i = 0; i < rvalidDelay - 1; i++) begin
                @(negedge clkrst_core_clk);
                checkOutput("no valid before rvalid", 32'(pc_valid_out), 32'd0);
                stepCycle();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clkrst_core_clk);
            checkOutput("no valid at rvalid", 32'(pc_valid_out), 32'd0);
            stepCycle();
            mem_rvalid = 1'b0;
        end
        @(negedge clkrst_core_clk);
        checkOutput("valid after response", 32'(pc_valid_out), 32'd1);
    endtask

    // Every cycle: any memory request and any offered result must match the model.
    always @(negedge clkrst_core_clk) begin
        if (monitorOn && !clkrst_core_rst) begin
            if (mem_req) begin
                if (!expReqActive) begin
                    checkOutput("unexpected mem_req", 32'(mem_req), 32'd0);
                end else begin
                    checkOutput("mem_addr", {2'b0, mem_addr}, {2'b0, expAddr});
                    checkOutput("mem_we", 32'(mem_we), 32'(expWe));
                    checkOutput("mem_be", 32'(mem_be), 32'(expBe));
                    checkOutput("mem_wdata", mem_wdata, expWdata);
                end
            end
            if (pc_valid_out) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected pc_valid_out", 32'(pc_valid_out), 32'd0);
                end else begin
                    monExp = expQ[0];
                    checkOutput("pc2wb_data", pc2wb_data, monExp.data);
                    checkOutput("pc2wb_pf", 32'(pc2wb_pf), 32'(monExp.pf));
                    checkOutput("pc2wb_misalign", 32'(pc2wb_misalign), 32'(monExp.mis));
                    if (pc_out_ok) void'(expQ.pop_front());
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios.
    initial begin
        clkrst_core_rst = 1'b1;
        dtlb2pc_paddr   = '0;
        dtlb2pc_pf      = 1'b0;
        pc_oper_type    = '0;
        pc_is_store     = 1'b0;
        pc_size         = '0;
        pc_signed       = 1'b0;
        pc_wdata        = '0;
        pc_valid_in     = 1'b0;
        pc_out_ok       = 1'b1;
        pipe_flush      = 1'b0;
        mem_gnt         = 1'b0;
        mem_rvalid      = 1'b0;
        mem_rdata       = '0;
        repeat (2) stepCycle();

        // Reset state, ready held low while reset is asserted.
        @(negedge clkrst_core_clk);
        checkOutput("reset pc_ready_in", 32'(pc_ready_in), 32'd0);
        checkOutput("reset pc_valid_out", 32'(pc_valid_out), 32'd0);
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset pc2wb_data", pc2wb_data, 32'd0);
        stepCycle();
        clkrst_core_rst = 1'b0;
        monitorOn       = 1'b1;
        @(negedge clkrst_core_clk);
        checkOutput("idle pc_ready_in", 32'(pc_ready_in), 32'd1);
        stepCycle();

        // Signed byte load from lane 3 with zero-wait memory.
        applyStimulus(LSU, 1'b0, BYTE, 1'b1, 32'h0000_1003, 32'h0, 1'b0, 32'h80AA_BBCC, 1'b1, waited);
        mem_gnt = 1'b1;
        @(negedge clkrst_core_clk);
        checkOutput("lb mem_req at N+1", 32'(mem_req), 32'd1);
        checkOutput("lb mem_be", 32'(mem_be), 32'h8);
        checkOutput("lb mem_addr", {2'b0, mem_addr}, 32'h400);
        stepCycle();
        mem_gnt      = 1'b0;
        expReqActive = 1'b0;
        mem_rvalid   = 1'b1;
        mem_rdata    = 32'h80AA_BBCC;
        @(negedge clkrst_core_clk);
        checkOutput("lb valid at N+2", 32'(pc_valid_out), 32'd0);
        stepCycle();
        mem_rvalid = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("lb valid at N+3", 32'(pc_valid_out), 32'd1);
        checkOutput("lb data", pc2wb_data, 32'hFFFF_FF80);
        stepCycle();

        // Half store: lanes 2/3, data replicated, result data zero.
        applyStimulus(LSU, 1'b1, HALF, 1'b0, 32'h0000_2002, 32'hABCD_1234, 1'b0, 32'h0, 1'b1, waited);
        @(negedge clkrst_core_clk);
        checkOutput("sh mem_we", 32'(mem_we), 32'd1);
        checkOutput("sh mem_be", 32'(mem_be), 32'hC);
        checkOutput("sh mem_wdata", mem_wdata, 32'h1234_1234);
        stepCycle();
        serveMem(0, 1, 32'hDEAD_BEEF);
        checkOutput("sh data", pc2wb_data, 32'h0);
        stepCycle();

        // Operations that never touch memory complete in the next cycle.
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_3001, 32'h0, 1'b0, 32'h0, 1'b1, waited);
        @(negedge clkrst_core_clk);
        checkOutput("misaligned word valid", 32'(pc_valid_out), 32'd1);
        checkOutput("misaligned word flag", 32'(pc2wb_misalign), 32'd1);
        checkOutput("misaligned word no req", 32'(mem_req), 32'd0);
        stepCycle();
        applyStimulus(LSU, 1'b0, BYTE, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 32'h0, 1'b1, waited);
        @(negedge clkrst_core_clk);
        checkOutput("page fault flag", 32'(pc2wb_pf), 32'd1);
        checkOutput("page fault no req", 32'(mem_req), 32'd0);
        stepCycle();
        applyStimulus(2'd2, 1'b0, WORD, 1'b0, 32'h0000_3001, 32'h0, 1'b0, 32'h0, 1'b1, waited);
        @(negedge clkrst_core_clk);
        checkOutput("non-lsu misalign flag", 32'(pc2wb_misalign), 32'd0);
        stepCycle();
        applyStimulus(LSU, 1'b0, HALF, 1'b1, 32'h0000_5001, 32'h0, 1'b0, 32'h0, 1'b1, waited);
        @(negedge clkrst_core_clk);
        checkOutput("misaligned half flag", 32'(pc2wb_misalign), 32'd1);
        stepCycle();

        // Grant and response in the same cycle, plus other lane/size mixes.
        applyStimulus(LSU, 1'b0, BYTE, 1'b0, 32'h0000_9002, 32'h0, 1'b0, 32'h1234_5678, 1'b1, waited);
        serveMem(0, 0, 32'h1234_5678);
        checkOutput("lbu lane2 data", pc2wb_data, 32'h0000_0034);
        stepCycle();
        applyStimulus(LSU, 1'b0, HALF, 1'b1, 32'h0000_A002, 32'h0, 1'b0, 32'h8001_0000, 1'b1, waited);
        serveMem(2, 2, 32'h8001_0000);
        checkOutput("lh upper data", pc2wb_data, 32'hFFFF_8001);
        stepCycle();
        applyStimulus(LSU, 1'b1, WORD, 1'b0, 32'h0000_B004, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, waited);
        serveMem(0, 1, 32'h0);
        stepCycle();
        applyStimulus(LSU, 1'b1, BYTE, 1'b0, 32'h0000_C001, 32'h0000_005A, 1'b0, 32'h0, 1'b1, waited);
        @(negedge clkrst_core_clk);
        checkOutput("sb mem_be", 32'(mem_be), 32'h2);
        checkOutput("sb mem_wdata", mem_wdata, 32'h5A5A_5A5A);
        stepCycle();
        serveMem(0, 1, 32'h0);
        stepCycle();

        // Slow grant, stalled consumer, then a back-to-back second load.
        pc_out_ok = 1'b0;
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_6000, 32'h0, 1'b0, 32'h1122_3344, 1'b1, waited);
        serveMem(3, 1, 32'h1122_3344);
        checkOutput("stalled data", pc2wb_data, 32'h1122_3344);
        stepCycle();
        @(negedge clkrst_core_clk);
        checkOutput("stalled valid held", 32'(pc_valid_out), 32'd1);
        checkOutput("stalled data held", pc2wb_data, 32'h1122_3344);
        checkOutput("stalled ready low", 32'(pc_ready_in), 32'd0);
        stepCycle();
        pc_out_ok = 1'b1;
        applyStimulus(LSU, 1'b0, HALF, 1'b0, 32'h0000_7002, 32'h0, 1'b0, 32'hBEEF_0000, 1'b1, waited);
        checkOutput("back-to-back accept wait", 32'(waited), 32'd0);
        serveMem(0, 1, 32'hBEEF_0000);
        checkOutput("back-to-back data", pc2wb_data, 32'h0000_BEEF);
        stepCycle();

        // A response while idle is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(negedge clkrst_core_clk);
        stepCycle();
        mem_rvalid = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("idle rvalid ignored", 32'(pc_valid_out), 32'd0);
        stepCycle();

        // Flush in REQ before grant withdraws the request.
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_D000, 32'h0, 1'b0, 32'h0, 1'b0, waited);
        pipe_flush = 1'b1;
        @(negedge clkrst_core_clk);
        checkOutput("flush blocks ready", 32'(pc_ready_in), 32'd0);
        stepCycle();
        pipe_flush   = 1'b0;
        expReqActive = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("flushed req withdrawn", 32'(mem_req), 32'd0);
        checkOutput("flushed req ready", 32'(pc_ready_in), 32'd1);
        stepCycle();

        // Flush in WAIT: drain the late response, second flush ignored.
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_E000, 32'h0, 1'b0, 32'h0, 1'b0, waited);
        mem_gnt = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        mem_gnt      = 1'b0;
        expReqActive = 1'b0;
        pipe_flush   = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        @(negedge clkrst_core_clk);
        checkOutput("drain ready low", 32'(pc_ready_in), 32'd0);
        checkOutput("drain no req", 32'(mem_req), 32'd0);
        stepCycle();
        pipe_flush = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        @(negedge clkrst_core_clk);
        checkOutput("drain holds after 2nd flush", 32'(pc_ready_in), 32'd0);
        stepCycle();
        mem_rvalid = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("drain done ready", 32'(pc_ready_in), 32'd1);
        checkOutput("drain no valid", 32'(pc_valid_out), 32'd0);
        stepCycle();

        // Flush in REQ with grant goes to DRAIN.
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_E100, 32'h0, 1'b0, 32'h0, 1'b0, waited);
        mem_gnt    = 1'b1;
        pipe_flush = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        mem_gnt      = 1'b0;
        pipe_flush   = 1'b0;
        expReqActive = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("req+gnt flush drains", 32'(pc_ready_in), 32'd0);
        stepCycle();
        mem_rvalid = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        mem_rvalid = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("req+gnt drain exit", 32'(pc_ready_in), 32'd1);
        stepCycle();

        // Flush in WAIT with same-cycle response returns straight to IDLE.
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_E200, 32'h0, 1'b0, 32'h0, 1'b0, waited);
        mem_gnt = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        mem_gnt      = 1'b0;
        expReqActive = 1'b0;
        pipe_flush   = 1'b1;
        mem_rvalid   = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        pipe_flush = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("wait flush+rvalid idle", 32'(pc_ready_in), 32'd1);
        stepCycle();

        // Reset while a result is held clears it.
        pc_out_ok = 1'b0;
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_F000, 32'h0, 1'b0, 32'h55AA_55AA, 1'b1, waited);
        serveMem(0, 1, 32'h55AA_55AA);
        stepCycle();
        clkrst_core_rst = 1'b1;
        @(negedge clkrst_core_clk);
        checkOutput("ready low in reset", 32'(pc_ready_in), 32'd0);
        stepCycle();
        clkrst_core_rst = 1'b0;
        pc_out_ok       = 1'b1;
        expQ.delete();
        @(negedge clkrst_core_clk);
        checkOutput("post-reset valid", 32'(pc_valid_out), 32'd0);
        checkOutput("post-reset data", pc2wb_data, 32'd0);
        stepCycle();

        // Reset in WAIT: the late response must not produce a result.
        applyStimulus(LSU, 1'b0, WORD, 1'b0, 32'h0000_F100, 32'h0, 1'b0, 32'h0, 1'b0, waited);
        mem_gnt = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        mem_gnt         = 1'b0;
        expReqActive    = 1'b0;
        clkrst_core_rst = 1'b1;
        @(negedge clkrst_core_clk);
        stepCycle();
        clkrst_core_rst = 1'b0;
        mem_rvalid      = 1'b1;
        mem_rdata       = 32'hFFFF_FFFF;
        @(negedge clkrst_core_clk);
        checkOutput("wait reset valid", 32'(pc_valid_out), 32'd0);
        checkOutput("wait reset pf", 32'(pc2wb_pf), 32'd0);
        checkOutput("wait reset misalign", 32'(pc2wb_misalign), 32'd0);
        stepCycle();
        mem_rvalid = 1'b0;
        @(negedge clkrst_core_clk);
        checkOutput("late rvalid ignored", 32'(pc_valid_out), 32'd0);
        checkOutput("late rvalid ready", 32'(pc_ready_in), 32'd1);
        stepCycle();

        checkOutput("result queue drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
